// File: rtl/gold_nonce_collector.sv
// Winning-nonce collector: lag-compensates core tickets, queues them in a small
// show-ahead FIFO and tracks the per-run sweep/drain lifecycle.
module gold_nonce_collector #(
  parameter logic [31:0] NONCE_LAG    = 32'd1,
  parameter int unsigned DEPTH_LOG2   = 2,
  parameter logic [7:0]  DRAIN_CYCLES = 8'd140
) (
  input  logic                  clk_h,
  input  logic                  host_break,
  input  logic                  start_stop,
  input  logic [31:0]           current_nonce,
  input  logic                  m2_ticket2moon,
  input  logic                  hash_cmplt,
  input  logic                  rd_en,
  output logic [31:0]           gold_nonce,
  output logic                  gold_valid,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  go_success,
  output logic                  go_unsuccess,
  output logic                  run_busy
);

  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            start_prev_q;
  logic [7:0]      drain_cnt_q, drain_cnt_d;
  logic            found_q, found_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     nonce_q, nonce_d;
  logic            valid_q;
  logic            succ_q, succ_d;
  logic            unsucc_q, unsucc_d;
  logic            busy_q;

  logic            start_rise;
  logic            accepting;
  logic            full;
  logic            push;
  logic            pop;
  logic [31:0]     push_val;

  assign push_val = current_nonce - NONCE_LAG;

  // Next-state, FIFO bookkeeping and pulse generation.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    found_d     = found_q;
    ovf_d       = ovf_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    nonce_d     = '0;
    succ_d      = 1'b0;
    unsucc_d    = 1'b0;

    start_rise = start_stop & ~start_prev_q;
    accepting  = (state_q == S_RUN) || (state_q == S_DRAIN);
    full       = (count_q == CW'(DEPTH));
    pop        = rd_en && (count_q != '0);
    push       = accepting && m2_ticket2moon && (!full || pop);

    if (accepting && m2_ticket2moon && full && !rd_en) begin
      ovf_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      found_d  = 1'b1;
      succ_d   = 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d  = S_RUN;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          count_d  = '0;
          found_d  = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (!start_stop) begin
          state_d = S_IDLE;
        end else if (hash_cmplt) begin
          // A one-cycle window degenerates into an immediate finish.
          if (DRAIN_CYCLES <= 8'd1) begin
            state_d  = S_DONE;
            unsucc_d = !found_d;
          end else begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_CYCLES;
          end
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q - 8'd1;
        if (!start_stop) begin
          state_d = S_IDLE;
        end else if (drain_cnt_q <= 8'd2) begin
          state_d  = S_DONE;
          unsucc_d = !found_d;
        end
      end
      S_DONE: begin
        if (!start_stop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Show-ahead head: a push into an empty slot at the new read pointer bypasses memory.
    if (count_d != '0) begin
      nonce_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_val : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_h) begin
    if (host_break) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      drain_cnt_q  <= '0;
      found_q      <= 1'b0;
      ovf_q        <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      nonce_q      <= '0;
      valid_q      <= 1'b0;
      succ_q       <= 1'b0;
      unsucc_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_stop;
      drain_cnt_q  <= drain_cnt_d;
      found_q      <= found_d;
      ovf_q        <= ovf_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      nonce_q      <= nonce_d;
      valid_q      <= (count_d != '0);
      succ_q       <= succ_d;
      unsucc_q     <= unsucc_d;
      busy_q       <= (state_d == S_RUN) || (state_d == S_DRAIN);
    end
  end

  // Storage needs no reset; only entries covered by the count are ever read.
  always_ff @(posedge clk_h) begin
    if (push && !host_break) begin
      mem_q[wr_ptr_q] <= push_val;
    end
  end

  assign gold_nonce   = nonce_q;
  assign gold_valid   = valid_q;
  assign fifo_count   = count_q;
  assign overflow     = ovf_q;
  assign go_success   = succ_q;
  assign go_unsuccess = unsucc_q;
  assign run_busy     = busy_q;

endmodule

// File: tb/tb_gold_nonce_collector.sv
// Bench for gold_nonce_collector: directed vector table, drain-window sequences
// and randomized traffic against a queue/deadline reference model.
module tb_gold_nonce_collector;

  localparam int DC    = 140;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic        clk_h = 1'b0;
  logic        host_break, start_stop, m2_ticket2moon, hash_cmplt, rd_en;
  logic [31:0] current_nonce;
  logic [31:0] gold_nonce;
  logic        gold_valid;
  logic [2:0]  fifo_count;
  logic        overflow, go_success, go_unsuccess, run_busy;

  always #5 clk_h = ~clk_h;

  gold_nonce_collector dut (
    .clk_h         (clk_h),
    .host_break    (host_break),
    .start_stop    (start_stop),
    .current_nonce (current_nonce),
    .m2_ticket2moon(m2_ticket2moon),
    .hash_cmplt    (hash_cmplt),
    .rd_en         (rd_en),
    .gold_nonce    (gold_nonce),
    .gold_valid    (gold_valid),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .go_success    (go_success),
    .go_unsuccess  (go_unsuccess),
    .run_busy      (run_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: queue of nonces, sticky flags, run phase and drain deadline.
  logic [31:0] mq[$];
  bit m_ovf, m_found, m_prev, e_succ, e_uns;
  int m_phase = P_IDLE;
  int m_deadline = 0;

  typedef struct {
    bit          hb, ss;
    logic [31:0] nonce;
    bit          tk, hc, rd;
    logic [31:0] e_nonce;
    bit          e_valid;
    int          e_count;
    bit          e_ovf, e_succ, e_uns, e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit acc;
    e_succ = 0;
    e_uns  = 0;
    if (host_break) begin
      mq.delete();
      m_ovf = 0; m_found = 0; m_prev = 0; m_phase = P_IDLE;
    end else begin
      acc = (m_phase == P_RUN) || (m_phase == P_DRAIN);
      if (m_phase == P_IDLE && start_stop && !m_prev) begin
        mq.delete();
        m_ovf = 0; m_found = 0; m_phase = P_RUN;
      end else begin
        if (rd_en && mq.size() > 0) void'(mq.pop_front());
        if (acc && m2_ticket2moon) begin
          if (mq.size() < DEPTH) begin
            mq.push_back(current_nonce - 32'd1);
            e_succ = 1; m_found = 1;
          end else begin
            m_ovf = 1;
          end
        end
        case (m_phase)
          P_RUN: begin
            if (!start_stop) m_phase = P_IDLE;
            else if (hash_cmplt) begin m_phase = P_DRAIN; m_deadline = cyc + DC; end
          end
          P_DRAIN: begin
            if (!start_stop) m_phase = P_IDLE;
            else if (cyc == m_deadline - 1) begin m_phase = P_DONE; e_uns = !m_found; end
          end
          P_DONE: if (!start_stop) m_phase = P_IDLE;
          default: ;
        endcase
      end
      m_prev = start_stop;
    end
  endtask

  task automatic tick(input bit hb, input bit ss, input logic [31:0] nonce,
                      input bit tk, input bit hc, input bit rd);
    host_break = hb; start_stop = ss; current_nonce = nonce;
    m2_ticket2moon = tk; hash_cmplt = hc; rd_en = rd;
    @(posedge clk_h);
    model_step();
    #1;
    chk("gold_nonce", gold_nonce, (mq.size() > 0) ? mq[0] : 32'h0);
    chk("gold_valid", 32'(gold_valid), 32'(mq.size() > 0));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("go_success", 32'(go_success), 32'(e_succ));
    chk("go_unsuccess", 32'(go_unsuccess), 32'(e_uns));
    chk("run_busy", 32'(run_busy), 32'((m_phase == P_RUN) || (m_phase == P_DRAIN)));
    cyc++;
  endtask

  task automatic v(input bit hb, input bit ss, input logic [31:0] nonce, input bit tk,
                   input bit hc, input bit rd, input logic [31:0] en, input bit ev,
                   input int ec, input bit eo, input bit es, input bit eu, input bit eb);
    vec_t t;
    t.hb = hb; t.ss = ss; t.nonce = nonce; t.tk = tk; t.hc = hc; t.rd = rd;
    t.e_nonce = en; t.e_valid = ev; t.e_count = ec; t.e_ovf = eo;
    t.e_succ = es; t.e_uns = eu; t.e_busy = eb;
    vq.push_back(t);
  endtask

  initial begin
    bit ss_r;
    // hb ss nonce tk hc rd | nonce valid count ovf succ uns busy
    v(1,0,32'h0,        0,0,0, 32'h0,        0,0,0,0,0,0);
    v(0,1,32'h0,        0,0,0, 32'h0,        0,0,0,0,0,1);
    v(0,1,32'h12345678, 1,0,0, 32'h12345677, 1,1,0,1,0,1);
    v(0,1,32'h0,        0,0,0, 32'h12345677, 1,1,0,0,0,1);
    v(0,1,32'h0,        0,0,1, 32'h0,        0,0,0,0,0,1);
    v(0,1,32'h0,        1,0,0, 32'hFFFFFFFF, 1,1,0,1,0,1);
    v(0,1,32'h0,        0,0,1, 32'h0,        0,0,0,0,0,1);
    v(0,1,32'h11,       1,0,0, 32'h10,       1,1,0,1,0,1);
    v(0,1,32'h21,       1,0,0, 32'h10,       1,2,0,1,0,1);
    v(0,1,32'h31,       1,0,0, 32'h10,       1,3,0,1,0,1);
    v(0,1,32'h41,       1,0,0, 32'h10,       1,4,0,1,0,1);
    v(0,1,32'h51,       1,0,0, 32'h10,       1,4,1,0,0,1);
    v(0,1,32'h61,       1,0,1, 32'h20,       1,4,1,1,0,1);
    v(0,1,32'h0,        0,0,1, 32'h30,       1,3,1,0,0,1);
    v(0,1,32'h0,        0,0,1, 32'h40,       1,2,1,0,0,1);
    v(0,1,32'h0,        0,0,1, 32'h60,       1,1,1,0,0,1);
    v(0,1,32'h0,        0,0,1, 32'h0,        0,0,1,0,0,1);
    v(0,1,32'h71,       1,0,1, 32'h70,       1,1,1,1,0,1);
    v(0,0,32'h0,        0,0,0, 32'h70,       1,1,1,0,0,0);
    v(0,0,32'h5,        1,0,0, 32'h70,       1,1,1,0,0,0);
    v(0,1,32'h0,        0,0,0, 32'h0,        0,0,0,0,0,1);

    foreach (vq[i]) begin
      tick(vq[i].hb, vq[i].ss, vq[i].nonce, vq[i].tk, vq[i].hc, vq[i].rd);
      chk($sformatf("vec%0d_nonce", i), gold_nonce, vq[i].e_nonce);
      chk($sformatf("vec%0d_valid", i), 32'(gold_valid), 32'(vq[i].e_valid));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vq[i].e_count));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vq[i].e_ovf));
      chk($sformatf("vec%0d_succ", i), 32'(go_success), 32'(vq[i].e_succ));
      chk($sformatf("vec%0d_uns", i), 32'(go_unsuccess), 32'(vq[i].e_uns));
      chk($sformatf("vec%0d_busy", i), 32'(run_busy), 32'(vq[i].e_busy));
    end

    // No-find run: hash_cmplt at t, go_unsuccess and run_busy=0 visible at t+140.
    tick(0,1,32'h0,0,1,0);
    for (int k = 1; k < DC; k++) tick(0,1,32'h0,0,0,0);
    chk("nofind_uns", 32'(go_unsuccess), 32'd1);
    chk("nofind_busy", 32'(run_busy), 32'd0);
    tick(0,1,32'h0,0,0,0);
    chk("nofind_uns_width", 32'(go_unsuccess), 32'd0);

    // Late ticket at t+139 is captured; one at t+141 is ignored.
    tick(0,0,32'h0,0,0,0);
    tick(0,1,32'h0,0,0,0);
    tick(0,1,32'h0,0,1,0);
    for (int k = 1; k < DC - 1; k++) tick(0,1,32'h0,0,0,0);
    tick(0,1,32'h00000ABC,1,0,0);
    chk("late_succ", 32'(go_success), 32'd1);
    chk("late_uns", 32'(go_unsuccess), 32'd0);
    chk("late_nonce", gold_nonce, 32'h00000ABB);
    chk("late_busy", 32'(run_busy), 32'd0);
    tick(0,1,32'h0,0,0,0);
    tick(0,1,32'h00000999,1,0,0);
    chk("after_window_count", 32'(fifo_count), 32'd1);
    chk("after_window_succ", 32'(go_success), 32'd0);

    // host_break mid-drain with two entries queued, then a clean restart.
    tick(0,0,32'h0,0,0,0);
    tick(0,1,32'h0,0,0,0);
    tick(0,1,32'h00000100,1,0,0);
    tick(0,1,32'h00000200,1,1,0);
    for (int k = 0; k < 10; k++) tick(0,1,32'h0,0,0,0);
    chk("brk_pre_count", 32'(fifo_count), 32'd2);
    tick(1,0,32'h0,0,0,0);
    chk("brk_count", 32'(fifo_count), 32'd0);
    chk("brk_busy", 32'(run_busy), 32'd0);
    chk("brk_uns", 32'(go_unsuccess), 32'd0);
    for (int k = 0; k < DC; k++) tick(0,0,32'h0,0,0,0);
    tick(0,1,32'h0,0,0,0);
    chk("restart_busy", 32'(run_busy), 32'd1);
    tick(0,1,32'h00000300,1,0,0);
    chk("restart_nonce", gold_nonce, 32'h000002FF);
    chk("restart_count", 32'(fifo_count), 32'd1);

    // Randomized traffic against the model.
    ss_r = 1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 399) == 0) ss_r = !ss_r;
      tick($urandom_range(0, 299) == 0, ss_r,
           ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom(),
           $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
